tach_velocity: RTL and testbench
================================

Name: tach_velocity

Overview:
Downstream consumer of the 16-bit quadrature tach counter's counth/countl bytes. Samples the free-running position count on a programmable period and computes the signed per-period delta, which is the shaft velocity in counts/period. Presents the velocity as high/low bytes for the 8-bit host bus, with a read-lock hold and a sticky overspeed flag. The counter itself is never frozen, so no counts are lost.

Parameters:
PERIOD_W, 16, width of the period input and the internal sample timer.
SPEED_LIMIT, 16'd4096, overspeed threshold; |delta| > SPEED_LIMIT sets overspeed.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
enable  input  1  run measurement; low returns to PRIME
period  input  PERIOD_W  sample period in clk cycles; 0 = timer halted
counth  input  8  tach counter high byte
countl  input  8  tach counter low byte
rdlock  input  1  host read in progress; holds velh/vell stable
ovclr  input  1  clears sticky overspeed
velh  output  8  velocity high byte (two's complement)
vell  output  8  velocity low byte
vel_valid  output  1  one-cycle pulse when velh/vell update
overspeed  output  1  sticky overspeed flag

Behaviour:
- Reset (rst_n low, async): timer=0, prev=0, delta=0, velh/vell=0, vel_valid=0, overspeed=0, pending=0, state=PRIME.
- Timer: counts up while enable=1 and period!=0. Tick when timer >= period-1; timer then returns to 0. Period 1 gives a tick every cycle. A period change mid-count takes effect immediately: if timer already >= new period-1, the tick fires that cycle.
- enable=0: timer cleared, state=PRIME, outputs hold last value, no vel_valid.
- State PRIME: on the first tick, prev <= {counth,countl}. No delta, no vel_valid. Go to RUN.
- State RUN: on a tick at cycle T:
  - delta = {counth,countl} - prev, mod 2^16, read as signed 16-bit.
  - prev <= current count.
  - Counter wrap (0xFFFF->0x0000) yields the correct signed delta when |true delta| < 32768.
- Output update, latency 1: at T+1, {velh,vell} <= delta and vel_valid=1 for one cycle, if rdlock=0.
- If rdlock=1 at T+1: outputs hold and pending=1 stores the newest delta; later ticks overwrite it. On the first cycle with rdlock=0, load the pending value, pulse vel_valid, and clear pending.
- Overspeed: set at T+1 when |delta| > SPEED_LIMIT. delta=-32768 counts as magnitude 32768. Setting is independent of rdlock.
- ovclr=1 clears overspeed. If a set and a clear occur in the same cycle, set wins.
- Simultaneous tick and enable falling: enable has priority; no sample is taken.

Optional Feature:
Macro TACHVEL_AVG4_EN.
- Defined: the output is the mean of the last 4 deltas.
  - 18-bit signed sum, arithmetic shift right by 2 (floor toward -inf), truncated to 16 bits.
  - History is cleared to 0 in PRIME, so the first three outputs average in zeros.
  - Overspeed uses the raw delta, not the average.
  - Output latency stays 1 cycle after the tick (running sum updated in the same cycle).
- Undefined: the output is the raw delta; no history registers exist.

Test Plan:
- Reset with count=0x1234, enable=1, period=10 -> first tick gives no vel_valid; next tick with count=0x1264 -> {velh,vell}=0x0030, one-cycle vel_valid 1 cycle after the tick.
- Wrap: prev=0xFFF0, next count=0x0010 -> velocity 0x0020. prev=0x0010, next=0xFFF0 -> 0xFFE0 (-32).
- rdlock held high across two ticks with deltas 5 then 7 -> outputs hold the old value; on rdlock fall, velocity=0x0007 with a single vel_valid pulse.
- Delta of +4097 with SPEED_LIMIT=4096 -> overspeed=1 and stays 1 after the next delta of 0; ovclr asserted in the same cycle as a new +5000 tick -> overspeed remains 1.
- enable dropped mid-period, then restored with count advanced by 100 -> no vel_valid until the second tick after restore; the baseline is re-primed, so the 100 counts are not reported.
- With TACHVEL_AVG4_EN defined, deltas 8, 8, 8, 8 -> outputs 2, 4, 6, 8; deltas -1, 0, 0, 0 from cleared history -> first output 0xFFFF (floor of -1/4).

Source files
------------

// File: rtl/tach_velocity.sv
// tach_velocity: samples a free-running 16-bit tach count every `period` clocks and
// reports the signed per-period count delta (shaft velocity) as two host-readable bytes,
// with a read-lock hold buffer and a sticky overspeed flag.
// Optional build macro TACHVEL_AVG4_EN: report the mean of the last four deltas instead
// of the raw delta.
module tach_velocity #(
  parameter int unsigned PERIOD_W    = 16,
  parameter logic [15:0] SPEED_LIMIT = 16'd4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [7:0]          counth,
  input  logic [7:0]          countl,
  input  logic                rdlock,
  input  logic                ovclr,
  output logic [7:0]          velh,
  output logic [7:0]          vell,
  output logic                vel_valid,
  output logic                overspeed
);

  typedef enum logic [0:0] {StPrime, StRun} state_e;

  state_e              r_state, w_state_next;
  logic [PERIOD_W-1:0] r_timer, w_timer_next;
  logic                w_tick;
  logic                w_prime_smp, w_run_smp;
  logic [15:0]         w_count, r_prev, w_delta, w_vel_new;
  logic [16:0]         w_mag;
  logic                w_ov_set;
  logic [15:0]         r_vel, r_pend_val;
  logic                r_vld, r_pend, r_ov;

  assign w_count = {counth, countl};

  // Tick once timer reaches period-1; a shortened period fires immediately.
  assign w_tick = enable && (period != '0) && (r_timer >= (period - PERIOD_W'(1)));

  // Sample timer next-state: cleared when disabled, frozen when period is 0.
  always_comb begin
    w_timer_next = r_timer;
    if (!enable) begin
      w_timer_next = '0;
    end else if (period != '0) begin
      w_timer_next = w_tick ? '0 : r_timer + PERIOD_W'(1);
    end
  end

  // Sample timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_timer <= '0;
    else        r_timer <= w_timer_next;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StPrime;
    else        r_state <= w_state_next;
  end

  // FSM next state: dropping enable always re-primes the baseline.
  always_comb begin
    w_state_next = r_state;
    if (!enable) begin
      w_state_next = StPrime;
    end else begin
      unique case (r_state)
        StPrime: if (w_tick) w_state_next = StRun;
        StRun:   w_state_next = StRun;
        default: w_state_next = StPrime;
      endcase
    end
  end

  // FSM outputs: which kind of sample this tick takes.
  always_comb begin
    w_prime_smp = 1'b0;
    w_run_smp   = 1'b0;
    unique case (r_state)
      StPrime: w_prime_smp = w_tick;
      StRun:   w_run_smp   = w_tick;
      default: ;
    endcase
  end

  // Baseline count: refreshed on every tick, priming or measuring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_prev <= '0;
    else if (w_tick) r_prev <= w_count;
  end

  // Modular subtraction handles counter wrap as long as |delta| < 32768.
  assign w_delta = w_count - r_prev;
  // 17-bit magnitude so that -32768 reads as +32768.
  assign w_mag    = w_delta[15] ? (17'h10000 - {1'b0, w_delta}) : {1'b0, w_delta};
  assign w_ov_set = w_run_smp && (w_mag > {1'b0, SPEED_LIMIT});

`ifdef TACHVEL_AVG4_EN
  logic [15:0]        r_hist0, r_hist1, r_hist2;
  logic signed [17:0] w_sum;

  assign w_sum = $signed({{2{w_delta[15]}}, w_delta}) + $signed({{2{r_hist0[15]}}, r_hist0})
               + $signed({{2{r_hist1[15]}}, r_hist1}) + $signed({{2{r_hist2[15]}}, r_hist2});
  // Arithmetic shift floors toward -inf.
  assign w_vel_new = 16'(w_sum >>> 2);

  // Delta history: zeroed while priming so early outputs average in zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist0 <= '0;
      r_hist1 <= '0;
      r_hist2 <= '0;
    end else if (r_state == StPrime) begin
      r_hist0 <= '0;
      r_hist1 <= '0;
      r_hist2 <= '0;
    end else if (w_run_smp) begin
      r_hist0 <= w_delta;
      r_hist1 <= r_hist0;
      r_hist2 <= r_hist1;
    end
  end
`else
  assign w_vel_new = w_delta;
`endif

  // Output bytes with read-lock hold; a held result waits in the pending slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vel      <= '0;
      r_vld      <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
    end else begin
      r_vld <= 1'b0;
      if (w_run_smp) begin
        if (!rdlock) begin
          r_vel  <= w_vel_new;
          r_vld  <= 1'b1;
          r_pend <= 1'b0;
        end else begin
          r_pend     <= 1'b1;
          r_pend_val <= w_vel_new;
        end
      end else if (r_pend && !rdlock && enable) begin
        r_vel  <= r_pend_val;
        r_vld  <= 1'b1;
        r_pend <= 1'b0;
      end
    end
  end

  // Sticky overspeed on the raw delta; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ov <= 1'b0;
    else if (w_ov_set) r_ov <= 1'b1;
    else if (ovclr)    r_ov <= 1'b0;
  end

  assign velh      = r_vel[15:8];
  assign vell      = r_vel[7:0];
  assign vel_valid = r_vld;
  assign overspeed = r_ov;

endmodule

// File: tb/tb_tach_velocity.sv
// Bench for tach_velocity: reset checks, a directed vector table (raw or AVG4 build),
// hand sequences for multi-cycle corners, and randomized traffic against a reference model.
module tb_tach_velocity;

  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] period = '0;
  logic [15:0]   count = 16'h0000;
  logic          rdlock = 1'b0;
  logic          ovclr = 1'b0;
  logic [7:0]    velh, vell;
  logic          vel_valid, overspeed;

  int n_vec = 0;
  int n_bad = 0;

  tach_velocity #(
    .PERIOD_W    (PW),
    .SPEED_LIMIT (16'd4096)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .period    (period),
    .counth    (count[15:8]),
    .countl    (count[7:0]),
    .rdlock    (rdlock),
    .ovclr     (ovclr),
    .velh      (velh),
    .vell      (vell),
    .vel_valid (vel_valid),
    .overspeed (overspeed)
  );

  always #5 clk = ~clk;

  // Directed vectors: inputs held for one clock, expected outputs just after that edge.
  typedef struct {
    bit          en;
    logic [15:0] per;
    logic [15:0] cnt;
    bit          rdl;
    bit          ovc;
    bit          ev;
    logic [15:0] evel;
    bit          eov;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit en, logic [15:0] per, logic [15:0] cnt, bit rdl, bit ovc,
                              bit ev, logic [15:0] evel, bit eov);
    vec_t r;
    r.en = en; r.per = per; r.cnt = cnt; r.rdl = rdl; r.ovc = ovc;
    r.ev = ev; r.evel = evel; r.eov = eov;
    tbl.push_back(r);
  endfunction

  task automatic check(input string name, input bit ev, input logic [15:0] evel, input bit eov);
    n_vec++;
    if (vel_valid !== ev || {velh, vell} !== evel || overspeed !== eov) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b vel=%h ov=%0b, want valid=%0b vel=%h ov=%0b",
               name, vel_valid, {velh, vell}, overspeed, ev, evel, eov);
    end
  endtask

  // Reference model: timer rule, baseline, pending slot and sticky flag as plain variables.
  int          m_timer;
  bit          m_primed;
  logic [15:0] m_prev;
  logic [15:0] m_vel;
  bit          m_valid;
  bit          m_ov;
  bit          m_pend;
  logic [15:0] m_pend_val;
  int          m_hist[$];

  function automatic void model_reset();
    m_timer = 0; m_primed = 0; m_prev = '0; m_vel = '0; m_valid = 0;
    m_ov = 0; m_pend = 0; m_pend_val = '0;
    m_hist.delete();
  endfunction

  function automatic logic [15:0] out_value(logic [15:0] d);
`ifdef TACHVEL_AVG4_EN
    int s = 0;
    int q;
    m_hist.push_front(int'($signed(d)));
    if (m_hist.size() > 4) void'(m_hist.pop_back());
    foreach (m_hist[k]) s += m_hist[k];
    q = s / 4;
    if (s < 0 && (s % 4) != 0) q = q - 1;
    return 16'(q);
`else
    return d;
`endif
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_step();
    bit          tick = 0;
    bit          upd = 0;
    bit          set = 0;
    logic [15:0] d;
    logic [15:0] v = '0;
    int          sd;
    if (!enable) begin
      m_timer  = 0;
      m_primed = 0;
    end else if (period != '0) begin
      if (m_timer >= int'(period) - 1) begin
        tick    = 1;
        m_timer = 0;
      end else begin
        m_timer++;
      end
    end
    m_valid = 0;
    if (tick && !m_primed) begin
      m_primed = 1;
      m_prev   = count;
      m_hist.delete();
    end else if (tick) begin
      d      = count - m_prev;
      m_prev = count;
      sd     = int'($signed(d));
      if (sd < 0) sd = -sd;
      set = (sd > 4096);
      v   = out_value(d);
      upd = 1;
    end
    if (upd) begin
      if (!rdlock) begin
        m_vel = v; m_valid = 1; m_pend = 0;
      end else begin
        m_pend = 1; m_pend_val = v;
      end
    end else if (m_pend && !rdlock && enable) begin
      m_vel = m_pend_val; m_valid = 1; m_pend = 0;
    end
    if (set)        m_ov = 1;
    else if (ovclr) m_ov = 0;
  endfunction

  // One model-checked clock: called at a negedge with inputs already driven.
  task automatic cycle(input string name);
    model_step();
    @(posedge clk);
    #1;
    check(name, m_valid, m_vel, m_ov);
    @(negedge clk);
  endtask

  initial begin
    int step;

`ifdef TACHVEL_AVG4_EN
    add(1, 1, 16'h0100, 0, 0, 0, 16'h0000, 0);
    add(1, 1, 16'h0108, 0, 0, 1, 16'h0002, 0);
    add(1, 1, 16'h0110, 0, 0, 1, 16'h0004, 0);
    add(1, 1, 16'h0118, 0, 0, 1, 16'h0006, 0);
    add(1, 1, 16'h0120, 0, 0, 1, 16'h0008, 0);
    add(0, 1, 16'h0120, 0, 0, 0, 16'h0008, 0);
    add(1, 1, 16'h0120, 0, 0, 0, 16'h0008, 0);
    add(1, 1, 16'h011F, 0, 0, 1, 16'hFFFF, 0);
    add(1, 1, 16'h011F, 0, 0, 1, 16'hFFFF, 0);
`else
    add(1, 1, 16'h1234, 0, 0, 0, 16'h0000, 0);  // prime: no output
    add(1, 1, 16'h1264, 0, 0, 1, 16'h0030, 0);
    add(0, 1, 16'hFFF0, 0, 0, 0, 16'h0030, 0);  // disabled: hold
    add(1, 1, 16'hFFF0, 0, 0, 0, 16'h0030, 0);  // re-prime
    add(1, 1, 16'h0010, 0, 0, 1, 16'h0020, 0);  // wrap up
    add(1, 1, 16'hFFF0, 0, 0, 1, 16'hFFE0, 0);  // wrap down
    add(1, 1, 16'hFFF5, 1, 0, 0, 16'hFFE0, 0);  // locked, pending 5
    add(1, 1, 16'hFFFC, 1, 0, 0, 16'hFFE0, 0);  // locked, pending 7
    add(1, 0, 16'hFFFC, 0, 0, 1, 16'h0007, 0);  // unlock flushes newest
    add(1, 0, 16'hFFFC, 0, 0, 0, 16'h0007, 0);  // single pulse
    add(1, 1, 16'hFFFC, 0, 0, 1, 16'h0000, 0);
    add(1, 1, 16'h0FFD, 0, 0, 1, 16'h1001, 1);  // +4097 overspeed
    add(1, 1, 16'h0FFD, 0, 0, 1, 16'h0000, 1);  // sticky
    add(1, 0, 16'h0FFD, 0, 0, 0, 16'h0000, 1);
    add(1, 1, 16'h2385, 0, 1, 1, 16'h1388, 1);  // set beats clear
    add(1, 0, 16'h2385, 0, 1, 0, 16'h1388, 0);  // clear alone
    add(1, 1, 16'hA385, 0, 0, 1, 16'h8000, 1);  // -32768 is over
    add(1, 0, 16'hA385, 0, 1, 0, 16'h8000, 0);
    add(1, 1, 16'hB385, 0, 0, 1, 16'h1000, 0);  // exactly the limit
    add(1, 1, 16'hA385, 0, 0, 1, 16'hF000, 0);
`endif

    repeat (3) @(negedge clk);
    check("reset", 1'b0, 16'h0000, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset", 1'b0, 16'h0000, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      enable = tbl[i].en;
      period = tbl[i].per;
      count  = tbl[i].cnt;
      rdlock = tbl[i].rdl;
      ovclr  = tbl[i].ovc;
      @(posedge clk);
      #1;
      check($sformatf("table[%0d]", i), tbl[i].ev, tbl[i].evel, tbl[i].eov);
      @(negedge clk);
    end

    // Asynchronous reset takes effect without a clock edge.
    ovclr  = 1'b0;
    rdlock = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_reset", 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // First tick primes, second reports +0x30.
    enable = 1'b0; period = 16'd10; count = 16'h1234;
    cycle("idle");
    enable = 1'b1;
    repeat (10) cycle("p10_prime");
    count = 16'h1264;
    repeat (10) cycle("p10_run");

    // Enable dropped mid-period; counts advanced while off are not reported.
    repeat (4) cycle("drop_pre");
    enable = 1'b0;
    cycle("drop_off");
    count  = count + 16'd100;
    enable = 1'b1;
    repeat (25) cycle("drop_restore");

    // Shortening the period below the running timer fires at once.
    repeat (6) cycle("per_pre");
    count  = count + 16'd9;
    period = 16'd4;
    cycle("per_shrink");
    repeat (6) cycle("per_post");

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      enable = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 39) == 0) period = PW'($urandom_range(0, 6));
      step   = int'($urandom_range(0, 1800)) - 900;
      count  = count + 16'(step);
      rdlock = ($urandom_range(0, 3) == 0);
      ovclr  = ($urandom_range(0, 15) == 0);
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
